// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-entry holding buffer in front of the shift register.
// Back-to-back words stream out with no gap bit while en stays high.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] shreg_r, shreg_s;
   logic [WIDTH-1:0] buf_r, buf_s;
   logic             buf_full_r, buf_full_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             din_ready_r;
   logic             busy_r;
   logic             accept_s;
   logic             load_s;
   logic             last_bit_s;

   // Advance the shift register by one bit, zero-filling behind the outgoing bit.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return {w[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, w[WIDTH-1:1]};
      end
   endfunction

   // Bit currently presented at the serial output.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[WIDTH-1];
      end else begin
         return w[0];
      end
   endfunction

   // Next-state, shift-register, counter and holding-buffer logic.
   always_comb begin
      state_s    = state_r;
      shreg_s    = shreg_r;
      cnt_s      = cnt_r;
      buf_s      = buf_r;
      buf_full_s = buf_full_r;
      load_s     = 1'b0;
      accept_s   = din_valid && din_ready_r;
      last_bit_s = (cnt_r == LAST_CNT);

      case (state_r)
         IDLE: begin
            if (buf_full_r) begin
               state_s = SHIFT;
               shreg_s = buf_r;
               cnt_s   = {CW{1'b0}};
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (!en) begin
               state_s = SHIFT;
            end else if (!last_bit_s) begin
               shreg_s = shift_word(shreg_r);
               cnt_s   = cnt_r + CW'(1'b1);
            end else if (buf_full_r) begin
               // Reload on the last-bit edge so the next word follows without a gap.
               shreg_s = buf_r;
               cnt_s   = {CW{1'b0}};
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
               shreg_s = {WIDTH{1'b0}};
               cnt_s   = {CW{1'b0}};
            end
         end
         default: begin
            state_s = IDLE;
            shreg_s = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
         end
      endcase

      // Accept needs an empty buffer and a load needs a full one, so they never coincide.
      if (accept_s) begin
         buf_s      = din;
         buf_full_s = 1'b1;
      end else if (load_s) begin
         buf_full_s = 1'b0;
      end else begin
         buf_full_s = buf_full_r;
      end
   end

   // State, datapath and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         shreg_r     <= {WIDTH{1'b0}};
         cnt_r       <= {CW{1'b0}};
         buf_r       <= {WIDTH{1'b0}};
         buf_full_r  <= 1'b0;
         din_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         shreg_r     <= shreg_s;
         cnt_r       <= cnt_s;
         buf_r       <= buf_s;
         buf_full_r  <= buf_full_s;
         din_ready_r <= !buf_full_s;
         busy_r      <= (state_s == SHIFT) || buf_full_s;
      end
   end

   // Serial outputs follow the shift register; en gates validity for the current cycle.
   always_comb begin
      sout       = (state_r == SHIFT) ? out_bit(shreg_r) : 1'b0;
      sout_valid = (state_r == SHIFT) && en;
      sout_last  = (state_r == SHIFT) && en && last_bit_s;
   end

   assign din_ready = din_ready_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first instance checked against a queue of
// expected bits, plus a small LSB-first instance checked directly.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         en;
   logic         sout;
   logic         sout_valid;
   logic         sout_last;
   logic         busy;

   logic [W-1:0] din2;
   logic         din_valid2;
   logic         din_ready2;
   logic         en2;
   logic         sout2;
   logic         sout_valid2;
   logic         sout_last2;
   logic         busy2;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [1:0]   exp_q[$];
   logic [7:0]   obs_word = 8'h00;
   int           run_len  = 0;
   int           last_run = 0;
   int           waits;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .en         (en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .reset      (reset),
      .din        (din2),
      .din_valid  (din_valid2),
      .din_ready  (din_ready2),
      .en         (en2),
      .sout       (sout2),
      .sout_valid (sout_valid2),
      .sout_last  (sout_last2),
      .busy       (busy2)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected bits are queued on every accepting edge; reset drops everything pending.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else if (din_valid && din_ready) begin
         for (int i = 0; i < W; i++) begin
            exp_q.push_back({din[W-1-i], (i == W-1) ? 1'b1 : 1'b0});
         end
      end
   end

   // Compare every valid serial bit against the head of the queue.
   always @(negedge clk) begin
      if (sout_valid) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_bit", 32'(1), 32'(0));
         end else begin
            check_val("sout_bit", 32'(sout), 32'(exp_q[0][1]));
            check_val("sout_last", 32'(sout_last), 32'(exp_q[0][0]));
            exp_q.delete(0);
         end
         obs_word <= {obs_word[6:0], sout};
         run_len  <= run_len + 1;
      end else begin
         if (run_len != 0) last_run <= run_len;
         run_len <= 0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [W-1:0] w, output int nwait);
      nwait     = 0;
      din       = w;
      din_valid = 1'b1;
      while (!din_ready && nwait < 100) begin
         @(posedge clk);
         #1;
         nwait++;
      end
      if (!din_ready) check_val("accept_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("idle_timeout", 32'(busy), 32'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      din        = 8'h00;
      din_valid  = 1'b1;
      en         = 1'b1;
      din2       = 8'h00;
      din_valid2 = 1'b0;
      en2        = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_din_ready", 32'(din_ready), 32'(1));
      check_val("rst_busy", 32'(busy), 32'(0));
      check_val("rst_sout_valid", 32'(sout_valid), 32'(0));
      check_val("rst_sout", 32'(sout), 32'(0));
      check_val("rst_sout_last", 32'(sout_last), 32'(0));
      @(posedge clk);
      #1;
      reset     = 1'b0;
      din_valid = 1'b0;

      // Single word, two-edge latency from accept to first bit.
      send(8'hE7, waits);
      @(negedge clk);
      check_val("lat_gap", 32'(sout_valid), 32'(0));
      @(negedge clk);
      check_val("lat_first", 32'(sout_valid), 32'(1));
      @(posedge clk);
      #1;
      wait_idle();
      check_val("e7_word", 32'(obs_word), 32'(8'hE7));
      check_val("e7_run", 32'(last_run), 32'(8));

      // Back-to-back words stream contiguously.
      send(8'hFF, waits);
      send(8'h00, waits);
      wait_idle();
      check_val("b2b_run", 32'(last_run), 32'(16));
      check_val("b2b_word", 32'(obs_word), 32'(8'h00));

      // Stall for three cycles after three bits of 0xA5.
      send(8'hA5, waits);
      repeat (4) @(posedge clk);
      #1;
      en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("stall_valid", 32'(sout_valid), 32'(0));
         check_val("stall_last", 32'(sout_last), 32'(0));
         check_val("stall_sout", 32'(sout), 32'(0));
      end
      @(posedge clk);
      #1;
      en = 1'b1;
      wait_idle();
      check_val("a5_word", 32'(obs_word), 32'(8'hA5));

      // Full buffer holds off a third word until the word boundary.
      send(8'h11, waits);
      send(8'h22, waits);
      check_val("w2_wait", 32'(waits), 32'(1));
      send(8'h33, waits);
      check_val("w3_wait", 32'(waits), 32'(7));
      wait_idle();
      check_val("w3_word", 32'(obs_word), 32'(8'h33));

      // Reset mid-word discards it; a word offered during reset is ignored.
      send(8'hF0, waits);
      repeat (4) @(posedge clk);
      #1;
      reset     = 1'b1;
      din       = 8'h3C;
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("midrst_valid", 32'(sout_valid), 32'(0));
      check_val("midrst_busy", 32'(busy), 32'(0));
      check_val("midrst_ready", 32'(din_ready), 32'(1));
      check_val("midrst_sout", 32'(sout), 32'(0));
      @(posedge clk);
      #1;
      reset     = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      check_val("rst_noaccept", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      send(8'h81, waits);
      wait_idle();
      check_val("post_rst_word", 32'(obs_word), 32'(8'h81));

      // LSB-first instance: 0x01 gives a 1 followed by seven 0s.
      check_val("lsb_ready", 32'(din_ready2), 32'(1));
      check_val("lsb_busy", 32'(busy2), 32'(0));
      din2       = 8'h01;
      din_valid2 = 1'b1;
      @(posedge clk);
      #1;
      din_valid2 = 1'b0;
      @(negedge clk);
      check_val("lsb_gap", 32'(sout_valid2), 32'(0));
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check_val("lsb_valid", 32'(sout_valid2), 32'(1));
         check_val("lsb_bit", 32'(sout2), (i == 0) ? 32'(1) : 32'(0));
         check_val("lsb_last", 32'(sout_last2), (i == W-1) ? 32'(1) : 32'(0));
      end
      @(negedge clk);
      check_val("lsb_end", 32'(sout_valid2), 32'(0));

      check_val("sb_empty", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, parallel word width in bits (legal range 2 to 32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port din_valid  input  1  din holds a word to transfer.
REQ-007 SHALL provide port din_ready  output  1  holding buffer empty; a word can be accepted.
REQ-008 SHALL provide port en  input  1  shift enable; low stalls serial output.
REQ-009 SHALL provide port sout  output  1  serial bit, to drive a downstream bit-stream detector input.
REQ-010 SHALL provide port sout_valid  output  1  sout carries a real bit this cycle.
REQ-011 SHALL provide port sout_last  output  1  sout is the final bit of its word.
REQ-012 SHALL provide port busy  output  1  shift register or holding buffer occupied.

Function
REQ-013 SHALL accept a word on any rising edge where din_valid && din_ready, writing din into a one-entry holding buffer.
REQ-014 SHALL drive din_ready from a register: high exactly when the holding buffer is empty; no combinational path from din_valid.
REQ-015 SHALL implement FSM states IDLE (shift register empty) and SHIFT (shift register holds a word).
REQ-016 IDLE -> SHIFT: on an edge where the buffer is full, load the shift register from the buffer, clear the buffer, and zero the bit counter.
REQ-017 In SHIFT with en=1: present one bit per cycle, advance the shift register and counter on each edge, and assert sout_valid.
REQ-018 In SHIFT with en=0: hold sout, the shift register and the counter; force sout_valid=0 and sout_last=0.
REQ-019 SHALL assert sout_last with sout_valid on the cycle where counter = WIDTH-1.
REQ-020 On the edge completing the last bit: if the buffer is full, reload the shift register, clear the buffer and stay in SHIFT (no gap bit); otherwise go to IDLE.
REQ-021 A word accepted on edge k SHALL have its first bit valid in the cycle after edge k+1 (2-edge latency from IDLE).
REQ-022 Simultaneous buffer drain and new accept are impossible because din_ready is registered; the buffer reopens the cycle after the drain.
REQ-023 Sustained throughput SHALL be one bit per cycle with contiguous sout_valid across back-to-back words while en=1.
REQ-024 Bit order per MSB_FIRST; the counter SHALL be ceil(log2(WIDTH)) bits and SHALL never exceed WIDTH-1.
REQ-025 sout SHALL read 0 whenever sout_valid=0 in IDLE.
REQ-026 busy SHALL be high when state=SHIFT or the buffer is full.

Reset
REQ-027 While reset=1: state=IDLE, buffer empty, counter=0, shift register=0, sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1 from the first reset edge.
REQ-028 din_valid and en SHALL be ignored while reset=1; no word is accepted on a reset edge.
REQ-029 Reset mid-word SHALL discard the partial word and the buffered word; no further bits of either are emitted.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, en=1, send 0xE7 -> sout 1,1,1,0,0,1,1,1 on 8 consecutive valid cycles, sout_last on the 8th, first bit 2 edges after accept.
REQ-031 Back-to-back 0xFF then 0x00 -> 16 contiguous sout_valid cycles, eight 1s then eight 0s, sout_last on cycles 8 and 16.
REQ-032 0xA5 with en=0 for 3 cycles after bit 3 -> sout_valid low for 3 cycles, then sequence resumes with no bit lost or repeated (1,0,1,0,0,1,0,1).
REQ-033 Word shifting, buffer full, din_valid held high -> din_ready=0 until the buffer drains at the word boundary; third word is not accepted early.
REQ-034 Reset asserted after bit 4 of 0xF0 -> next cycle sout_valid=0, busy=0, din_ready=1; the next word 0x81 serializes cleanly.
REQ-035 MSB_FIRST=0, send 0x01 -> first bit 1, then seven 0s.
